// File: rtl/frame_pkg.sv
// Shared frame definitions for the filter pipeline: default memory geometry and the
// streamer state encoding, used by both the pixel processor and the frame streamer.
package frame_pkg;

    localparam int unsigned FRAME_ADDR_BITS  = 15;
    localparam int unsigned FRAME_PIX_WIDTH  = 24;
    localparam int unsigned FRAME_NUM_PIXELS = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SEND  = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5
    } state_e;

    // True when a frame of num_pixels words fits an addr_bits-wide address space.
    function automatic bit frame_size_ok(input int unsigned addr_bits,
                                         input int unsigned num_pixels);
        return (num_pixels >= 1) && (64'(num_pixels) <= (64'd1 << addr_bits));
    endfunction

endpackage

// File: rtl/byte_sum8.sv
// 8-bit clear/add accumulator; o_sum_next is the value the register takes at the next edge,
// so a caller can present the sum including the byte being accepted this cycle.
module byte_sum8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_add,
    input  logic [7:0] i_data,
    output logic [7:0] o_sum_next
);

    logic [7:0] r_sum;
    logic [7:0] w_sum_next;

    always_comb begin
        w_sum_next = r_sum;
        if (i_clear) begin
            w_sum_next = 8'd0;
        end else if (i_add) begin
            w_sum_next = r_sum + i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= 8'd0;
        end else begin
            r_sum <= w_sum_next;
        end
    end

    assign o_sum_next = w_sum_next;

endmodule

// File: rtl/frame_streamer.sv
// Reads the destination frame memory sequentially and emits the low byte of each word on a
// valid/ready stream. Define FRAME_STREAMER_CHECKSUM_EN to append an 8-bit sum byte per frame.
module frame_streamer
    import frame_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = FRAME_ADDR_BITS,
    parameter int unsigned PIX_WIDTH  = FRAME_PIX_WIDTH,
    parameter int unsigned NUM_PIXELS = FRAME_NUM_PIXELS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    input  logic [PIX_WIDTH-1:0] i_mem_do,
    output logic [7:0]           o_out_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready
);

    if (!frame_size_ok(ADDR_BITS, NUM_PIXELS)) begin : g_bad_frame_size
        $fatal(1, "frame_streamer: NUM_PIXELS must be in 1..2**ADDR_BITS");
    end

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_PIXELS - 1);

    state_e               r_state;
    logic [ADDR_BITS-1:0] r_cnt;
    logic [ADDR_BITS-1:0] r_mem_addr;
    logic [7:0]           r_out_data;
    logic                 r_out_valid;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_unused_mem_hi;

    assign w_accept        = (r_state == SEND) && i_out_ready;
    assign w_last          = (r_cnt == LAST_ADDR);
    assign w_unused_mem_hi = ^i_mem_do[PIX_WIDTH-1:8];

`ifdef FRAME_STREAMER_CHECKSUM_EN
    logic       w_sum_clear;
    logic [7:0] w_sum_next;

    assign w_sum_clear = (r_state == IDLE) && i_start;

    byte_sum8 u_byte_sum8 (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_sum_clear),
        .i_add      (w_accept),
        .i_data     (r_out_data),
        .o_sum_next (w_sum_next)
    );
`endif

    // mem_addr is loaded on entry to FETCH so the RAM samples it at the end of FETCH and its
    // registered output is readable during WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_cnt      <= '0;
                        r_mem_addr <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                FETCH: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_out_data  <= i_mem_do[7:0];
                    r_out_valid <= 1'b1;
                    r_state     <= SEND;
                end
                SEND: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
`ifdef FRAME_STREAMER_CHECKSUM_EN
                            r_out_data  <= w_sum_next;
                            r_out_valid <= 1'b1;
                            r_state     <= CSUM;
`else
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
`endif
                        end else begin
                            r_cnt      <= r_cnt + 1'b1;
                            r_mem_addr <= r_cnt + 1'b1;
                            r_state    <= FETCH;
                        end
                    end
                end
                CSUM: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_mem_addr  = r_mem_addr;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;

endmodule
